uart_rx_fsm: RTL and testbench

UART receiver for the UART block, mirroring the transmit FSM on the receive side. Recovers 8N1 frames (start bit, DATA_BITS data bits LSB first, one stop bit) from the asynchronous serial line `rx` using a 16x oversampling tick from the shared baud generator. Completed bytes are presented on `data_out` with a one-cycle `rx_done` pulse. A bad stop bit is flagged on `frame_error`.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx_fsm.sv | 136 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive FSMs.
// Holds the state codes and the default frame geometry.
package uart_pkg;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;

  // The TX FSM relies on these same codes, so keep the values fixed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous rx line into the clk domain and flags its falling edges.
// All flops reset to 1, which is the idle line level.
module uart_rx_sync (
  input  logic clk,
  input  logic areset_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign rx_s = sync_q;
  assign fall = hist_q & ~sync_q;

endmodule : uart_rx_sync

// File: rtl/uart_rx_fsm.sv
// 8N1 UART receiver driven by a 16x oversampling tick.
// It samples mid-bit, reports each byte with rx_done and each bad stop bit with frame_error.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 rx,
  input  logic                 baud_tick_16x,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk      (clk),
    .areset_n (areset_n),
    .rx       (rx),
    .rx_s     (rx_s),
    .fall     (fall)
  );

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 done_d;
  logic                 ferr_d;
  logic                 busy_d;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      sr_q        <= '0;
      data_out    <= '0;
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      bcnt_q      <= bcnt_d;
      sr_q        <= sr_d;
      data_out    <= data_d;
      rx_done     <= done_d;
      frame_error <= ferr_d;
      busy        <= busy_d;
    end
  end

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    sr_d    = sr_q;
    data_d  = data_out;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        tcnt_d = '0;
        bcnt_d = '0;
        if (fall) state_d = START;
      end

      START: begin
        if (baud_tick_16x) begin
          if (tcnt_q == T_MID) begin
            tcnt_d  = '0;
            // A line that is high again at mid start bit was only a glitch.
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (baud_tick_16x) begin
          if (tcnt_q == T_END) begin
            sr_d   = {rx_s, sr_q[DATA_BITS-1:1]};
            tcnt_d = '0;
            if (bcnt_q == B_LAST) begin
              state_d = STOP;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (baud_tick_16x) begin
          if (tcnt_q == T_END) begin
            tcnt_d  = '0;
            state_d = IDLE;
            if (rx_s) begin
              data_d = sr_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule : uart_rx_fsm

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: frames are serialised onto rx at 64 clk per bit,
// and each rx_done/frame_error pulse is matched against the queued expectation.
`timescale 1ns/1ps
module tb_uart_rx_fsm;

  localparam int BIT_CLKS = 64;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       rx = 1'b1;
  logic       baud_tick_16x;
  logic [7:0] data_out;
  logic       rx_done;
  logic       frame_error;
  logic       busy;

  logic [1:0] tdiv = 2'd0;
  exp_t       sb[$];
  logic [7:0] last_data = 8'h00;
  logic       prev_pulse = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;
  int         done_cnt = 0;
  int         ferr_cnt = 0;

  uart_rx_fsm #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk           (clk),
    .areset_n      (areset_n),
    .rx            (rx),
    .baud_tick_16x (baud_tick_16x),
    .data_out      (data_out),
    .rx_done       (rx_done),
    .frame_error   (frame_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tdiv <= tdiv + 2'd1;
  assign baud_tick_16x = (tdiv == 2'd3);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    exp_t e;
    e.is_err = ~stop_bit;
    e.data   = stop_bit ? d : last_data;
    sb.push_back(e);
    if (stop_bit) last_data = d;
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(BIT_CLKS / 2);
      check("busy_in_frame", busy, 1);
      wait_clks(BIT_CLKS / 2);
    end
    rx = stop_bit;
    wait_clks(BIT_CLKS);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rx_done || frame_error) begin
      check("pulse_exclusive", rx_done & frame_error, 0);
      check("pulse_width", prev_pulse, 0);
      check("busy_at_pulse", busy, 0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {rx_done, frame_error}, 0);
      end else begin
        e = sb.pop_front();
        check(e.is_err ? "pulse_kind_ferr" : "pulse_kind_done",
              {rx_done, frame_error}, e.is_err ? 2'b01 : 2'b10);
        check("data_out_at_pulse", data_out, e.data);
      end
      if (rx_done) done_cnt++;
      else         ferr_cnt++;
    end
    prev_pulse = rx_done | frame_error;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   n;

    // Reset state
    areset_n = 1'b0;
    rx       = 1'b1;
    wait_clks(3);
    check("rst_data_out", data_out, 0);
    check("rst_rx_done", rx_done, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_busy", busy, 0);
    areset_n = 1'b1;
    wait_clks(20);
    check("idle_busy", busy, 0);

    // Single valid byte
    send_frame(8'hA5, 1'b1);
    wait_clks(40);
    check("a5_data_out", data_out, 8'hA5);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clks(40);
    check("b2b_data_out", data_out, 8'hFF);

    // 5-tick glitch: false start
    rx = 1'b0;
    wait_clks(20);
    rx = 1'b1;
    wait_clks(120);
    check("glitch_busy", busy, 0);
    check("glitch_data_out", data_out, 8'hFF);

    // Bad stop bit
    send_frame(8'h3C, 1'b0);
    rx = 1'b1;
    wait_clks(40);
    check("ferr_data_out", data_out, 8'hFF);

    // Break: three frame times low, then a good frame
    e.is_err = 1'b1;
    e.data   = last_data;
    sb.push_back(e);
    rx = 1'b0;
    wait_clks(1000);
    check("break_idle_busy", busy, 0);
    wait_clks(30 * BIT_CLKS - 1000);
    check("break_no_retrigger", busy, 0);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    send_frame(8'h81, 1'b1);
    wait_clks(40);
    check("after_break_data_out", data_out, 8'h81);

    // Reset during data bit 4 of 0x5A
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx = ((8'h5A >> i) & 8'h01) != 0;
      wait_clks(BIT_CLKS);
    end
    rx = 1'b1;
    wait_clks(BIT_CLKS / 2);
    check("pre_reset_busy", busy, 1);
    areset_n = 1'b0;
    #1;
    check("async_rst_data_out", data_out, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_rx_done", rx_done, 0);
    check("async_rst_frame_error", frame_error, 0);
    last_data = 8'h00;
    wait_clks(4);
    areset_n = 1'b1;
    wait_clks(5 * BIT_CLKS);
    check("post_rst_busy", busy, 0);
    check("post_rst_data_out", data_out, 0);
    send_frame(8'h5A, 1'b1);
    wait_clks(40);
    check("post_rst_frame", data_out, 8'h5A);

    // Drain the scoreboard with a bounded wait
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
    check("rx_done_count", done_cnt, 5);
    check("frame_error_count", ferr_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_rx_fsm
